// File: rtl/external_memory_pkg.sv
// Shared types for the external memory port: access sizes, FSM states
// and the array index width helper.
package external_memory_pkg;

  typedef enum logic [1:0] {
    OP_BYTE = 2'd0,
    OP_HALF = 2'd1,
    OP_WORD = 2'd2,
    OP_RSVD = 2'd3
  } op_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  function automatic int index_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational fault detection, byte-enable generation and lane steering
// for one 32-bit word-organised memory port.
module mem_lane_align
  import external_memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          ROM_WORDS   = 0,
  localparam int         IW          = index_width(DEPTH_WORDS)
) (
  input  logic          is_write,
  input  op_size_t      op_size,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [31:0]   rdata_word,
  output logic          fault,
  output logic [IW-1:0] word_index,
  output logic [3:0]    byte_en,
  output logic [31:0]   wdata_lane,
  output logic [31:0]   rdata_aligned
);

  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [32:0] offset;
  logic [1:0]  lane;
  logic        misaligned;
  logic        out_of_range;
  logic        rom_zone;
  logic [31:0] shifted;

  // Bit 32 of the 33-bit difference is the borrow, i.e. addr below base.
  assign offset = {1'b0, addr} - {1'b0, BASE_ADDR};

  generate
    if (ROM_WORDS > 0) begin : g_rom
      assign rom_zone = (offset >> 2) < 33'(ROM_WORDS);
    end else begin : g_no_rom
      assign rom_zone = 1'b0;
    end
  endgenerate

  always_comb begin
    lane         = addr[1:0];
    word_index   = offset[IW+1:2];
    misaligned   = ((op_size == OP_HALF) && addr[0]) ||
                   ((op_size == OP_WORD) && (lane != 2'd0));
    out_of_range = offset[32] || (offset >= SPAN);
    fault        = (op_size == OP_RSVD) || misaligned || out_of_range ||
                   (is_write && rom_zone);

    byte_en = 4'b0000;
    case (op_size)
      OP_BYTE: byte_en = 4'b0001 << lane;
      OP_HALF: byte_en = 4'b0011 << lane;
      OP_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    // A faulted access must never reach the array.
    if (fault) begin
      byte_en = 4'b0000;
    end

    wdata_lane = wdata << {lane, 3'b000};
    shifted    = rdata_word >> {lane, 3'b000};

    rdata_aligned = 32'd0;
    case (op_size)
      OP_BYTE: rdata_aligned = {24'd0, shifted[7:0]};
      OP_HALF: rdata_aligned = {16'd0, shifted[15:0]};
      OP_WORD: rdata_aligned = shifted;
      default: rdata_aligned = 32'd0;
    endcase
  end

endmodule

// File: rtl/external_memory_port.sv
// Clocked external memory: one outstanding load/store over valid/ready,
// programmable wait states, fault checking and registered responses.
module external_memory_port
  import external_memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter int          ROM_WORDS   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_write,
  input  logic [1:0]  req_op_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_fault
);

  localparam int IW = index_width(DEPTH_WORDS);

  mem_state_t  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        is_write_q, is_write_d;
  op_size_t    op_size_q, op_size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic        commit;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          fault;
  logic [IW-1:0] word_index;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lane;
  logic [31:0]   rdata_aligned;

  mem_lane_align #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_WORDS(DEPTH_WORDS),
    .ROM_WORDS  (ROM_WORDS)
  ) u_align (
    .is_write     (is_write_q),
    .op_size      (op_size_q),
    .addr         (addr_q),
    .wdata        (wdata_q),
    .rdata_word   (mem_q[word_index]),
    .fault        (fault),
    .word_index   (word_index),
    .byte_en      (byte_en),
    .wdata_lane   (wdata_lane),
    .rdata_aligned(rdata_aligned)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    is_write_d  = is_write_q;
    op_size_d   = op_size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    commit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_write_d = req_is_write;
          op_size_d  = op_size_t'(req_op_size);
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            count_d = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (count_q == 4'd0) begin
          state_d = RESP;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      RESP: begin
        // First edge in RESP performs the access and raises the response.
        if (!rsp_valid_q) begin
          commit      = is_write_q;
          rsp_valid_d = 1'b1;
          rsp_fault_d = fault;
          rsp_data_d  = (fault || is_write_q) ? 32'd0 : rdata_aligned;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = 32'd0;
          rsp_fault_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      is_write_q  <= 1'b0;
      op_size_q   <= OP_BYTE;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      is_write_q  <= is_write_d;
      op_size_q   <= op_size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Array contents survive reset; byte_en is already zero on a fault.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (commit && byte_en[b]) begin
        mem_q[word_index][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

endmodule
